// File: rtl/doodle_pkg.sv
// Shared geometry constants and scan FSM states for the doodle collision logic.
package doodle_pkg;

    localparam int unsigned SCREEN_WIDTH  = 400;
    localparam int unsigned SCREEN_HEIGHT = 700;
    localparam int unsigned BLOCK_WIDTH   = 40;
    localparam int unsigned BLOCK_HEIGHT  = 5;
    localparam int unsigned DOODLE_WIDTH  = 20;

    localparam int unsigned BIH   = SCREEN_HEIGHT / BLOCK_HEIGHT;
    localparam int unsigned BIW   = SCREEN_WIDTH / BLOCK_WIDTH;
    localparam int unsigned COUNT = BIH * BIW;
    localparam int unsigned IW    = $clog2(COUNT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } scan_state_t;

endpackage : doodle_pkg

// File: rtl/block_hit_check.sv
// Combinational test of one block against the latched doodle feet position.
module block_hit_check #(
    parameter int unsigned DOODLE_WIDTH = 20,
    parameter int unsigned BLOCK_WIDTH  = 40,
    parameter int unsigned BLOCK_HEIGHT = 5
) (
    input  logic        active,
    input  logic [31:0] doodle_x,
    input  logic [31:0] doodle_y,
    input  logic [31:0] block_x,
    input  logic [31:0] block_y,
    output logic        hit_c
);

    logic [32:0] doodle_right;
    logic [32:0] block_right;
    logic [32:0] block_top;

    // 33-bit sums so edges near 2^32 never wrap
    always_comb begin
        doodle_right = {1'b0, doodle_x} + 33'(DOODLE_WIDTH);
        block_right  = {1'b0, block_x} + 33'(BLOCK_WIDTH);
        block_top    = {1'b0, block_y} + 33'(BLOCK_HEIGHT);
        hit_c = active
              & (doodle_right > {1'b0, block_x})
              & ({1'b0, doodle_x} < block_right)
              & (block_y <= doodle_y)
              & ({1'b0, doodle_y} <= block_top);
    end

endmodule : block_hit_check

// File: rtl/block_collision_scanner.sv
// Per-frame sequential scan of the block arrays for the first block the falling doodle lands on.
module block_collision_scanner
    import doodle_pkg::*;
(
    input  logic                clk,
    input  logic                resetN,
    input  logic                frameTick,
    input  logic [31:0]         doodleX,
    input  logic [31:0]         doodleY,
    input  logic                doodleFalling,
    input  logic [COUNT*32-1:0] blocksX,
    input  logic [COUNT*32-1:0] blocksY,
    input  logic [COUNT-1:0]    isBlockActive,
    output logic                hasCollide,
    output logic [31:0]         collisionX,
    output logic [31:0]         collisionY,
    output logic [IW-1:0]       collisionIndex,
    output logic                scanDone,
    output logic                busy,
    output logic                overrun
);

    localparam int unsigned RW = (BIH > 1) ? $clog2(BIH) : 1;
    localparam int unsigned CW = (BIW > 1) ? $clog2(BIW) : 1;

    scan_state_t   state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [RW-1:0] row, row_d;
    logic [CW-1:0] col, col_d;
    logic [31:0]   lat_x, lat_x_d;
    logic [31:0]   lat_y, lat_y_d;
    logic          idle_done, idle_done_d;
    logic          has_collide_d, scan_done_d, busy_d, overrun_d;
    logic [31:0]   collision_x_d, collision_y_d;
    logic [IW-1:0] collision_index_d;

    logic [31:0]   blk_x, blk_y;
    logic          blk_active;
    logic          hit_c;

    // Select the live value of block idx (no snapshot of the arrays)
    always_comb begin
        blk_x      = blocksX[32'(idx) * 32'd32 +: 32];
        blk_y      = blocksY[32'(idx) * 32'd32 +: 32];
        blk_active = isBlockActive[idx];
    end

    block_hit_check #(
        .DOODLE_WIDTH (DOODLE_WIDTH),
        .BLOCK_WIDTH  (BLOCK_WIDTH),
        .BLOCK_HEIGHT (BLOCK_HEIGHT)
    ) u_hit (
        .active   (blk_active),
        .doodle_x (lat_x),
        .doodle_y (lat_y),
        .block_x  (blk_x),
        .block_y  (blk_y),
        .hit_c    (hit_c)
    );

    // Next-state, counter and output logic
    always_comb begin
        state_d           = state;
        idx_d             = idx;
        row_d             = row;
        col_d             = col;
        lat_x_d           = lat_x;
        lat_y_d           = lat_y;
        idle_done_d       = 1'b0;
        has_collide_d     = 1'b0;
        scan_done_d       = idle_done;
        busy_d            = busy;
        overrun_d         = 1'b0;
        collision_x_d     = collisionX;
        collision_y_d     = collisionY;
        collision_index_d = collisionIndex;

        case (state)
            S_IDLE: begin
                if (frameTick) begin
                    lat_x_d = doodleX;
                    lat_y_d = doodleY;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    if (doodleFalling) begin
                        state_d = S_SCAN;
                        busy_d  = 1'b1;
                    end else begin
                        // rising doodle: report an empty scan one cycle later
                        idle_done_d = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (frameTick) begin
                    overrun_d = 1'b1;
                end
                if (hit_c) begin
                    collision_x_d     = 32'(col);
                    collision_y_d     = 32'(row);
                    collision_index_d = idx;
                    has_collide_d     = 1'b1;
                    scan_done_d       = 1'b1;
                    busy_d            = 1'b0;
                    state_d           = S_IDLE;
                end else if (idx == IW'(COUNT - 1)) begin
                    scan_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    idx_d = idx + IW'(1);
                    if (row == RW'(BIH - 1)) begin
                        row_d = '0;
                        col_d = col + CW'(1);
                    end else begin
                        row_d = row + RW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters, latched doodle and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= S_IDLE;
            idx            <= '0;
            row            <= '0;
            col            <= '0;
            lat_x          <= '0;
            lat_y          <= '0;
            idle_done      <= 1'b0;
            hasCollide     <= 1'b0;
            scanDone       <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
            collisionX     <= '0;
            collisionY     <= '0;
            collisionIndex <= '0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            row            <= row_d;
            col            <= col_d;
            lat_x          <= lat_x_d;
            lat_y          <= lat_y_d;
            idle_done      <= idle_done_d;
            hasCollide     <= has_collide_d;
            scanDone       <= scan_done_d;
            busy           <= busy_d;
            overrun        <= overrun_d;
            collisionX     <= collision_x_d;
            collisionY     <= collision_y_d;
            collisionIndex <= collision_index_d;
        end
    end

endmodule : block_collision_scanner

// File: tb/tb_block_collision_scanner.sv
// Randomized and directed checks of block_collision_scanner against a behavioural model.
module tb_block_collision_scanner;
    import doodle_pkg::*;

    logic                clk = 1'b0;
    logic                resetN = 1'b1;
    logic                frameTick = 1'b0;
    logic [31:0]         doodleX = '0;
    logic [31:0]         doodleY = '0;
    logic                doodleFalling = 1'b0;
    logic [COUNT*32-1:0] blocksX;
    logic [COUNT*32-1:0] blocksY;
    logic [COUNT-1:0]    isBlockActive;
    logic                hasCollide;
    logic [31:0]         collisionX;
    logic [31:0]         collisionY;
    logic [IW-1:0]       collisionIndex;
    logic                scanDone;
    logic                busy;
    logic                overrun;

    logic [31:0] bx [COUNT];
    logic [31:0] by [COUNT];
    logic        act [COUNT];

    int n_checks = 0;
    int n_errors = 0;
    longint prev_cx = 0, prev_cy = 0, prev_ci = 0;

    block_collision_scanner dut (
        .clk            (clk),
        .resetN         (resetN),
        .frameTick      (frameTick),
        .doodleX        (doodleX),
        .doodleY        (doodleY),
        .doodleFalling  (doodleFalling),
        .blocksX        (blocksX),
        .blocksY        (blocksY),
        .isBlockActive  (isBlockActive),
        .hasCollide     (hasCollide),
        .collisionX     (collisionX),
        .collisionY     (collisionY),
        .collisionIndex (collisionIndex),
        .scanDone       (scanDone),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Standard layout: block i at column i/BIH, row i%BIH; all inactive
    task automatic layout_default();
        for (int i = 0; i < int'(COUNT); i++) begin
            bx[i]  = 32'((i / int'(BIH)) * int'(BLOCK_WIDTH));
            by[i]  = 32'((i % int'(BIH)) * int'(BLOCK_HEIGHT));
            act[i] = 1'b0;
        end
    endtask

    task automatic pack_blocks();
        for (int i = 0; i < int'(COUNT); i++) begin
            blocksX[i*32 +: 32] = bx[i];
            blocksY[i*32 +: 32] = by[i];
            isBlockActive[i]    = act[i];
        end
    endtask

    // Reference: lowest active index whose rectangle the feet point touches, or -1
    function automatic int ref_hit(input longint x, input longint y);
        for (int i = 0; i < int'(COUNT); i++) begin
            longint b_x = longint'(bx[i]);
            longint b_y = longint'(by[i]);
            if (act[i] && (x + DOODLE_WIDTH > b_x) && (x < b_x + BLOCK_WIDTH)
                && (b_y <= y) && (y <= b_y + BLOCK_HEIGHT))
                return i;
        end
        return -1;
    endfunction

    // One frame scan; tick2 = edge of a second tick (0 none), rst_at = edge to reset (0 none)
    task automatic run_scan(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic fall, input int tick2, input int rst_at, input bit b2b);
        int hit_idx, exp_edge, done_edge, hc_count, ov_count, ov_edge;
        bit hc_at_done, busy_seen;
        longint got_cx, got_cy, got_ci, exp_cx, exp_cy, exp_ci;
        hit_idx   = fall ? ref_hit(longint'(x), longint'(y)) : -1;
        exp_edge  = !fall ? 1 : (hit_idx >= 0 ? hit_idx + 1 : int'(COUNT));
        done_edge = 0; hc_count = 0; ov_count = 0; ov_edge = 0;
        hc_at_done = 0; busy_seen = 0;
        got_cx = 0; got_cy = 0; got_ci = 0;

        doodleX = x; doodleY = y; doodleFalling = fall; frameTick = 1'b1;
        @(posedge clk); #1;
        frameTick = 1'b0;
        // position must be held internally, not re-sampled
        doodleX = $urandom; doodleY = $urandom; doodleFalling = 1'($urandom);
        check({tag, "/busy_e0"}, 64'(busy), 64'(fall));

        for (int n = 1; n <= int'(COUNT) + 10 && done_edge == 0; n++) begin
            @(posedge clk); #1;
            frameTick = 1'b0;
            if (busy) busy_seen = 1;
            if (hasCollide) hc_count++;
            if (overrun) begin ov_count++; ov_edge = n; end
            if (scanDone) begin
                done_edge  = n;
                hc_at_done = hasCollide;
                got_cx = longint'(collisionX);
                got_cy = longint'(collisionY);
                got_ci = longint'(collisionIndex);
                check({tag, "/busy_done"}, 64'(busy), 64'd0);
            end
            if (n == rst_at) begin
                resetN = 1'b0;
                #1;
                check({tag, "/rst_outs"},
                      {hasCollide, scanDone, busy, overrun, collisionX, collisionY, 32'(collisionIndex)} == '0 ? 64'd1 : 64'd0,
                      64'd1);
                prev_cx = 0; prev_cy = 0; prev_ci = 0;
                @(posedge clk); @(posedge clk); #1;
                check({tag, "/rst_nopulse"}, 64'(scanDone | hasCollide | overrun), 64'd0);
                resetN = 1'b1;
                @(posedge clk); #1;
                check({tag, "/rst_idle"}, 64'(scanDone | busy), 64'd0);
                return;
            end
            if (n + 1 == tick2) frameTick = 1'b1;
        end

        exp_cx = (hit_idx >= 0) ? longint'(hit_idx / int'(BIH)) : prev_cx;
        exp_cy = (hit_idx >= 0) ? longint'(hit_idx % int'(BIH)) : prev_cy;
        exp_ci = (hit_idx >= 0) ? longint'(hit_idx) : prev_ci;
        check({tag, "/done_edge"}, 64'(done_edge), 64'(exp_edge));
        check({tag, "/hit"}, 64'(hc_at_done), 64'(hit_idx >= 0));
        check({tag, "/hit_pulses"}, 64'(hc_count), 64'(hit_idx >= 0 ? 1 : 0));
        check({tag, "/col"}, 64'(got_cx), 64'(exp_cx));
        check({tag, "/row"}, 64'(got_cy), 64'(exp_cy));
        check({tag, "/index"}, 64'(got_ci), 64'(exp_ci));
        check({tag, "/overrun_n"}, 64'(ov_count), 64'(tick2 > 0 ? 1 : 0));
        check({tag, "/overrun_at"}, 64'(ov_edge), 64'(tick2 > 0 ? tick2 : 0));
        check({tag, "/busy_seen"}, 64'(busy_seen), 64'(fall && exp_edge > 1));
        prev_cx = exp_cx; prev_cy = exp_cy; prev_ci = exp_ci;
        if (!b2b) begin
            @(posedge clk); #1;
            check({tag, "/pulse_end"}, 64'(scanDone | hasCollide), 64'd0);
        end
    endtask

    initial begin
        int pick, k;
        layout_default();
        pack_blocks();
        #2 resetN = 1'b0;
        #1;
        check("reset/outs",
              {hasCollide, scanDone, busy, overrun, collisionX, collisionY, 32'(collisionIndex)} == '0 ? 64'd1 : 64'd0,
              64'd1);
        @(posedge clk); @(posedge clk); #1;
        resetN = 1'b1;
        @(posedge clk); #1;
        check("reset/idle", 64'(busy | scanDone), 64'd0);

        // single block at origin
        act[0] = 1'b1; pack_blocks();
        run_scan("t1", 32'd10, 32'd3, 1'b1, 0, 0, 0);

        // two overlapping blocks: lowest index wins, then the other one
        act[141] = 1'b1; pack_blocks();
        run_scan("t2a", 32'd35, 32'd5, 1'b1, 0, 0, 0);
        act[0] = 1'b0; pack_blocks();
        run_scan("t2b", 32'd35, 32'd5, 1'b1, 0, 0, 0);

        // horizontal edges are strict
        layout_default(); act[140] = 1'b1; pack_blocks();
        run_scan("t3_x20", 32'd20, 32'd2, 1'b1, 0, 0, 0);
        run_scan("t3_x21", 32'd21, 32'd2, 1'b1, 0, 0, 0);
        run_scan("t3_x79", 32'd79, 32'd2, 1'b1, 0, 0, 0);
        run_scan("t3_x80", 32'd80, 32'd2, 1'b1, 0, 0, 0);
        // vertical edges are inclusive
        run_scan("t3_y0", 32'd50, 32'd0, 1'b1, 0, 0, 0);
        run_scan("t3_y5", 32'd50, 32'd5, 1'b1, 0, 0, 0);
        run_scan("t3_y6", 32'd50, 32'd6, 1'b1, 0, 0, 0);

        // rising doodle: immediate empty scan, then a tick in the done cycle is accepted
        layout_default(); act[0] = 1'b1; pack_blocks();
        run_scan("t4", 32'd10, 32'd3, 1'b0, 0, 0, 1);
        run_scan("t4_b2b", 32'd10, 32'd3, 1'b1, 0, 0, 1);
        run_scan("t4_b2b2", 32'd10, 32'd3, 1'b1, 0, 0, 0);

        // last block, overrun while busy
        layout_default(); act[COUNT-1] = 1'b1; pack_blocks();
        run_scan("t5", 32'd360, 32'd695, 1'b1, 10, 0, 0);

        // reset mid-scan, then a clean rescan
        run_scan("t6_rst", 32'd360, 32'd695, 1'b1, 10, 50, 0);
        run_scan("t6_after", 32'd360, 32'd695, 1'b1, 0, 0, 0);

        // coordinates near 2^32: sums must not wrap
        layout_default();
        bx[0] = 32'hFFFF_FFF0; by[0] = 32'hFFFF_FFFC; act[0] = 1'b1; pack_blocks();
        run_scan("wrap", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);

        // random active sets on the standard layout
        for (int r = 0; r < 8; r++) begin
            layout_default();
            pick = 0;
            for (int j = 0; j < 1 + int'($urandom_range(0, 3)); j++) begin
                k = int'($urandom_range(0, COUNT - 1));
                act[k] = 1'b1;
                pick = k;
            end
            pack_blocks();
            if ($urandom_range(0, 1) == 1) begin
                doodleX = bx[pick] + 32'($urandom_range(0, 39)) - 32'(($urandom_range(0, 1) == 1 && bx[pick] >= 19) ? 19 : 0);
                doodleY = by[pick] + 32'($urandom_range(0, 6));
            end else begin
                doodleX = 32'($urandom_range(0, SCREEN_WIDTH - 1));
                doodleY = 32'($urandom_range(0, SCREEN_HEIGHT - 1));
            end
            run_scan($sformatf("rnd%0d", r), doodleX, doodleY, 1'($urandom_range(0, 3) != 0), 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_block_collision_scanner
